fmesh_route_encoder: RTL and testbench
======================================

Name: fmesh_route_encoder

Overview:
- Router-side route-computation front end for the fmesh topology.
- Takes a destination endpoint address and the router's own X/Y. Produces the 4-bit coded destination port {x,y,a,b} and the local-port number that fmesh_destp_decoder consumes.
- Results leave through a registered 2-entry elastic buffer with valid/ready on both sides.
- Sits between the header-flit extractor and the look-ahead destination-port register of each router.

Parameters:
- NX, 4, routers in X.
- NY, 4, routers in Y.
- NL, 2, local endpoints per router.
- EAw, 7, endpoint address width: {p, y, x}, with x in the low log2(NX) bits and y in the next log2(NY) bits.
- ROUTE_TYPE, "DETERMINISTIC", "DETERMINISTIC" (XY) or "FULL_ADAPTIVE".
- TAGw, 4, opaque sideband carried alongside each request.
- Derived: NXw=log2(NX), NYw=log2(NY), EPw=EAw-NXw-NYw, P=4+NL, PLw=log2(P).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- current_x  in  NXw  this router's X.
- current_y  in  NYw  this router's Y.
- in_valid  in  1  request valid.
- in_ready  out  1  buffer can accept.
- in_dest_e_addr  in  EAw  destination endpoint address.
- in_tag  in  TAGw  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_dest_port_coded  out  4  {x,y,a,b}.
- out_endp_localp_num  out  PLw  router port index for final delivery.
- out_tag  out  TAGw  sideband echo.
- out_addr_err  out  1  destination address was invalid.
- err_count  out  8  saturating count of invalid addresses accepted.

Behaviour:
- Address split: {ep,ey,ex}=in_dest_e_addr.
  - valid = ex<=NX-1 & ey<=NY-1 & ep<=P-1.
  - ep values 1..4 (EAST, NORTH, WEST, SOUTH) are mesh-edge endpoints.
- Encoding, computed combinationally on the input side and registered into the buffer:
  - X move: a=1, x=(ex>current_x) (1=EAST).
  - Y move: b=1, y=(ey<current_y) (1=NORTH, toward y=0).
  - DETERMINISTIC: if ex!=current_x, X move only (b=0, y=0). Else if ey!=current_y, Y move only (a=0, x=0).
  - FULL_ADAPTIVE: each of a and b is set independently when its axis differs; x and y are set as above.
  - Unused x/y bits are 0.
  - Arrived (ex==current_x & ey==current_y):
    - ep==0 or ep>=5: coded=4'b0000, localp=ep.
    - ep==EAST: 4'b1010. ep==WEST: 4'b0010.
    - ep==NORTH: 4'b0101. ep==SOUTH: 4'b0001.
  - localp is 0 whenever coded!=0000.
- Invalid address: coded=0000, localp=0, out_addr_err=1; err_count increments by 1 on acceptance and saturates at 255.
- Handshake:
  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
  - in_ready=(occupancy<2), driven from registers, with no combinational path from out_ready.
  - Latency: entry accepted in cycle N is visible at the output no earlier than N+1; there is no same-cycle bypass.
  - Order is FIFO; head payload is held stable while out_valid&!out_ready.
- Occupancy boundaries:
  - Occupancy 0: out_valid=0.
  - Occupancy 1: simultaneous push and pop keeps occupancy 1; the new entry becomes head in the next cycle.
  - Occupancy 2: in_ready=0 and no push occurs, even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
- current_x/current_y are sampled at acceptance only; later changes do not alter buffered entries.
- Reset, asynchronous, active while reset=0, including mid-operation:
  - Occupancy 0; buffered entries are discarded.
  - out_valid=0, in_ready=0; in_ready becomes 1 on the first clk edge after reset deasserts.
  - out_dest_port_coded=0, out_endp_localp_num=0, out_tag=0, out_addr_err=0, err_count=0.

Test Plan:
- NX=NY=4, NL=2, EAw=7, current=(1,1), XY:
  - in_dest_e_addr=7 (x3, y1, p0) -> one cycle later out_valid=1, coded=4'b1010, localp=0.
  - addr=1 (x1, y0) -> coded=4'b0101.
- At (1,1):
  - addr=85 (p5 local) -> coded=0000, localp=5.
  - addr=37 (p NORTH edge) -> coded=0101, localp=0.
- Invalid addr=117 (p7) -> coded=0000, out_addr_err=1, err_count 0->1. Send 300 invalid requests -> err_count holds 255.
- FULL_ADAPTIVE, current=(0,0), addr=14 (x2, y3) -> coded=4'b1011. Same stimulus under XY -> 4'b1010.
- Backpressure:
  - out_ready=0, push tags A,B,C -> in_ready=0 after B; C is not accepted; head stays A stable.
  - Release out_ready -> A,B emerge in order; in_ready returns the cycle after the first pop.
- Assert reset low with 2 entries buffered -> out_valid=0 immediately and err_count=0. After release, in_ready=1 after one edge, and no stale entries appear.

Source files
------------

// File: rtl/fmesh_route_encoder.sv
// Route-computation front end for an fmesh router: turns a destination endpoint
// address into the coded {x,y,a,b} port plus local-port number, via a 2-entry elastic buffer.
module fmesh_route_encoder #(
    parameter int unsigned NX         = 4,
    parameter int unsigned NY         = 4,
    parameter int unsigned NL         = 2,
    parameter int unsigned EAw        = 7,
    parameter string       ROUTE_TYPE = "DETERMINISTIC",
    parameter int unsigned TAGw       = 4,
    localparam int unsigned NXw       = $clog2(NX),
    localparam int unsigned NYw       = $clog2(NY),
    localparam int unsigned EPw       = EAw - NXw - NYw,
    localparam int unsigned P         = 4 + NL,
    localparam int unsigned PLw       = $clog2(P)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NXw-1:0]   current_x,
    input  logic [NYw-1:0]   current_y,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EAw-1:0]   in_dest_e_addr,
    input  logic [TAGw-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_dest_port_coded,
    output logic [PLw-1:0]   out_endp_localp_num,
    output logic [TAGw-1:0]  out_tag,
    output logic             out_addr_err,
    output logic [7:0]       err_count
);

    localparam bit          ADAPTIVE = (ROUTE_TYPE == "FULL_ADAPTIVE");
    localparam int unsigned XMAX     = NX - 1;
    localparam int unsigned YMAX     = NY - 1;
    localparam int unsigned PMAX     = P - 1;

    localparam logic [EPw-1:0] EP_EAST  = EPw'(1);
    localparam logic [EPw-1:0] EP_NORTH = EPw'(2);
    localparam logic [EPw-1:0] EP_WEST  = EPw'(3);
    localparam logic [EPw-1:0] EP_SOUTH = EPw'(4);

    typedef struct packed {
        logic [3:0]      coded;
        logic [PLw-1:0]  localp;
        logic [TAGw-1:0] tag;
        logic            err;
    } entry_t;

    logic [NXw-1:0] ex;
    logic [NYw-1:0] ey;
    logic [EPw-1:0] ep;
    logic           addr_ok;
    logic           dx;
    logic           dy;
    entry_t         enc_c;

    assign {ep, ey, ex} = in_dest_e_addr;

    // Range checks are widened to 32 bits so power-of-two meshes do not yield constant compares.
    assign addr_ok = (32'(ex) <= XMAX) && (32'(ey) <= YMAX) && (32'(ep) <= PMAX);
    assign dx      = (ex != current_x);
    assign dy      = (ey != current_y);

    // Port encoding of the incoming request.
    always_comb begin
        enc_c     = '0;
        enc_c.tag = in_tag;
        if (!addr_ok) begin
            enc_c.err = 1'b1;
        end else if (!dx && !dy) begin
            case (ep)
                EP_EAST:  enc_c.coded = 4'b1010;
                EP_NORTH: enc_c.coded = 4'b0101;
                EP_WEST:  enc_c.coded = 4'b0010;
                EP_SOUTH: enc_c.coded = 4'b0001;
                default:  enc_c.localp = PLw'(ep);
            endcase
        end else if (ADAPTIVE) begin
            enc_c.coded[1] = dx;
            enc_c.coded[0] = dy;
            enc_c.coded[3] = dx && (ex > current_x);
            enc_c.coded[2] = dy && (ey < current_y);
        end else if (dx) begin
            enc_c.coded[1] = 1'b1;
            enc_c.coded[3] = (ex > current_x);
        end else begin
            enc_c.coded[0] = 1'b1;
            enc_c.coded[2] = (ey < current_y);
        end
    end

    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [1:0]  occ_q, occ_d;
    logic        valid_q, valid_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        push;
    logic        pop;

    assign push = in_valid && rdy_q;
    assign pop  = valid_q && out_ready;

    // Elastic buffer next state; head_q always drives the output payload.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        err_cnt_d = err_cnt_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = enc_c;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = enc_c;
                end else if (push) begin
                    tail_d = enc_c;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
        endcase
        if (push && enc_c.err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        valid_d = (occ_d != 2'd0);
        rdy_d   = (occ_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= 2'd0;
            valid_q   <= 1'b0;
            rdy_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            valid_q   <= valid_d;
            rdy_q     <= rdy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready            = rdy_q;
    assign out_valid           = valid_q;
    assign out_dest_port_coded = head_q.coded;
    assign out_endp_localp_num = head_q.localp;
    assign out_tag             = head_q.tag;
    assign out_addr_err        = head_q.err;
    assign err_count           = err_cnt_q;

endmodule

// File: tb/tb_fmesh_route_encoder.sv
// Scoreboard bench for fmesh_route_encoder: XY and fully-adaptive instances share stimulus,
// each result is checked against a spec-level route model in FIFO order.
module tb_fmesh_route_encoder;

    localparam int NX   = 4;
    localparam int NY   = 4;
    localparam int NL   = 2;
    localparam int P    = 4 + NL;
    localparam int TAGw = 4;

    typedef struct packed {
        logic [3:0]      coded;
        logic [2:0]      localp;
        logic [TAGw-1:0] tag;
        logic            err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      cur_x;
    logic [1:0]      cur_y;
    logic            in_valid;
    logic [6:0]      addr;
    logic [TAGw-1:0] tag;
    logic            out_ready;
    bit              rnd_rdy;
    bit              armed;

    logic            in_ready_w  [2];
    logic            out_valid_w [2];
    logic [3:0]      coded_w     [2];
    logic [2:0]      localp_w    [2];
    logic [TAGw-1:0] tag_w       [2];
    logic            err_w       [2];
    logic [7:0]      errcnt_w    [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   err_m    = 0;

    fmesh_route_encoder #(.NX(NX), .NY(NY), .NL(NL), .EAw(7), .ROUTE_TYPE("DETERMINISTIC"), .TAGw(TAGw)) dut_xy (
        .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_dest_e_addr(addr), .in_tag(tag),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_dest_port_coded(coded_w[0]), .out_endp_localp_num(localp_w[0]),
        .out_tag(tag_w[0]), .out_addr_err(err_w[0]), .err_count(errcnt_w[0])
    );

    fmesh_route_encoder #(.NX(NX), .NY(NY), .NL(NL), .EAw(7), .ROUTE_TYPE("FULL_ADAPTIVE"), .TAGw(TAGw)) dut_fa (
        .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_dest_e_addr(addr), .in_tag(tag),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_dest_port_coded(coded_w[1]), .out_endp_localp_num(localp_w[1]),
        .out_tag(tag_w[1]), .out_addr_err(err_w[1]), .err_count(errcnt_w[1])
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Route rules evaluated on integer coordinates.
    function automatic exp_t ref_route(int a, int cx, int cy, bit adaptive, logic [TAGw-1:0] t);
        exp_t r;
        int   ex, ey, ep;
        bit   mx, my;
        r     = '0;
        r.tag = t;
        ex    = a % NX;
        ey    = (a / NX) % NY;
        ep    = a / (NX * NY);
        if (ex >= NX || ey >= NY || ep >= P) begin
            r.err = 1'b1;
            return r;
        end
        if (ex == cx && ey == cy) begin
            case (ep)
                1:       r.coded = 4'b1010;
                2:       r.coded = 4'b0101;
                3:       r.coded = 4'b0010;
                4:       r.coded = 4'b0001;
                default: r.localp = 3'(ep);
            endcase
            return r;
        end
        mx = (ex != cx);
        my = (ey != cy);
        if (!adaptive && mx) my = 1'b0;
        r.coded = {mx && (ex > cx), my && (ey < cy), mx, my};
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_port(int d, int sz, exp_t e);
        check($sformatf("out_valid[%0d]", d), 32'(out_valid_w[d]), 32'(sz != 0));
        check($sformatf("in_ready[%0d]", d), 32'(in_ready_w[d]), 32'(armed && sz < 2));
        if (out_valid_w[d] && sz != 0)
            check($sformatf("payload[%0d]", d),
                  32'({coded_w[d], localp_w[d], tag_w[d], err_w[d]}), 32'(e));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // Monitor: compares at the falling edge, pops when a transfer will occur on the next rise.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++)
                check($sformatf("reset_state[%0d]", d),
                      32'({out_valid_w[d], in_ready_w[d], coded_w[d], localp_w[d], tag_w[d], err_w[d], errcnt_w[d]}), 32'(0));
        end else begin
            check_port(0, q0.size(), (q0.size() != 0) ? q0[0] : exp_t'('0));
            check_port(1, q1.size(), (q1.size() != 0) ? q1[0] : exp_t'('0));
            check("err_count[0]", 32'(errcnt_w[0]), 32'(err_m));
            check("err_count[1]", 32'(errcnt_w[1]), 32'(err_m));
            if (out_valid_w[0] && out_ready && q0.size() != 0) void'(q0.pop_front());
            if (out_valid_w[1] && out_ready && q1.size() != 0) void'(q1.pop_front());
        end
    end

    task automatic push_expected(int a, logic [TAGw-1:0] t);
        exp_t e;
        e = ref_route(a, int'(cur_x), int'(cur_y), 1'b0, t);
        q0.push_back(e);
        q1.push_back(ref_route(a, int'(cur_x), int'(cur_y), 1'b1, t));
        if (e.err && err_m < 255) err_m++;
    endtask

    task automatic send(logic [6:0] a, logic [TAGw-1:0] t, int max_wait, output bit acc);
        addr     = a;
        tag      = t;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_w[0];
            @(posedge clk);
            if (acc) push_expected(int'(a), t);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
        idle(1);
        check("drain", 32'(q0.size() + q1.size()), 32'(0));
    endtask

    task automatic send_ok(logic [6:0] a, logic [TAGw-1:0] t);
        bit acc;
        send(a, t, 50, acc);
        check("accept", 32'(acc), 32'(1));
    endtask

    initial begin
        bit       acc;
        int       dir_a [5] = '{7, 1, 85, 37, 117};
        in_valid  = 1'b0;
        addr      = '0;
        tag       = '0;
        out_ready = 1'b1;
        cur_x     = 2'd1;
        cur_y     = 2'd1;
        rnd_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(1);

        for (int i = 0; i < 5; i++) send_ok(7'(dir_a[i]), 4'(i + 1));
        drain();

        cur_x = 2'd0;
        cur_y = 2'd0;
        send_ok(7'd14, 4'h6);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++)
            send_ok(7'($urandom_range(6, 7) * 16 + $urandom_range(0, 15)), 4'($urandom));
        drain();
        check("err_saturated", 32'(errcnt_w[0]), 32'(255));

        out_ready = 1'b0;
        cur_x     = 2'd2;
        cur_y     = 2'd1;
        send_ok(7'd3, 4'hA);
        send_ok(7'd16, 4'hB);
        send(7'd5, 4'hC, 3, acc);
        check("third_rejected", 32'(acc), 32'(0));
        idle(3);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cur_x = 2'($urandom);
            cur_y = 2'($urandom);
            send_ok(7'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();

        out_ready = 1'b0;
        cur_x     = 2'd1;
        cur_y     = 2'd1;
        send_ok(7'd117, 4'h1);
        send_ok(7'd7, 4'h2);
        reset    = 1'b0;
        q0.delete();
        q1.delete();
        err_m    = 0;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b1;
        out_ready = 1'b1;
        idle(4);
        send_ok(7'd1, 4'h3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
